red_pitaya_pwm_sd: RTL and testbench
====================================

// Module: red_pitaya_pwm_sd
// PURPOSE
//  Slow-analog output stage driven by the DSP router's 14-bit pwm0/pwm1 outputs (one instance per channel).
//  Converts a signed 14-bit sample into a glitch-free PWM bitstream.
//  Bits above FW set the duty per period; the FW LSBs are spread over 2^FW periods by 1st-order sigma-delta.
//  Output feeds the RC-filtered PWM pins; the sample is taken once per period, never mid-period.
// PARAMETERS
//  CCW   8   period counter width; period = 2^CCW clk cycles
//  FW    6   fractional (dither) bits; CCW+FW must equal 14
// PORTS
//  clk_i     in   1       processing clock (125 MHz)
//  rst_i     in   1       asynchronous reset, active high
//  dat_i     in   14      signed sample (two's complement), -8192..8191
//  en_i      in   1       output enable, sampled with dat_i
//  pwm_o     out  1       PWM bitstream, registered
//  sync_o    out  1       1-cycle pulse on the first cycle of every period
//  duty_o    out  CCW+1   duty (high cycles) of the current period, 0..2^CCW
// BEHAVIOUR
//  Clock and reset: one clock clk_i; reset rst_i is asynchronous and active-high.
//  Reset (async assert): cnt=all-ones, acc=0, duty=0; outputs pwm_o=0, sync_o=0, duty_o=0.
//  Reset release: dat_i is sampled on the first clk edge after deassert; the first period starts on the next cycle.
//  Offset: code = dat_i + 8192 (flip MSB), unsigned 0..16383; int = code[13:FW]; frac = code[FW-1:0].
//  Counter: cnt increments by 1 each cycle and wraps 2^CCW-1 -> 0. No stall, no load.
//  Boundary cycle (cnt == 2^CCW-1), dat_i and en_i are sampled:
//    s = acc + frac (FW+1 bits); carry = s[FW]; acc <= s[FW-1:0]
//    duty <= en_i ? int + carry : 0; if !en_i then acc <= 0
//  Period cycle k (cnt==k, k = 0..2^CCW-1): pwm_o = (k < duty), registered.
//    The new duty is visible on pwm_o in the cycle immediately after the boundary cycle.
//  sync_o=1 exactly in period cycle 0; duty_o holds duty for the entire period.
//  Duty range: code 0 -> duty 0 (never high); int=2^CCW-1 with carry -> duty 2^CCW (high the whole period).
//  Duty width is CCW+1 bits, so int+carry never overflows; no saturation logic is needed.
//  dat_i/en_i changes on non-boundary cycles have no effect; the output never glitches within a period.
//  Average: high cycles over 2^FW periods = code exactly (DC-exact, error <1 LSB over any 2^FW-period window).
//  Reset mid-period: pwm_o drops to 0 asynchronously; the restart follows the reset-release rule (acc history lost).
//  en_i low: pwm_o=0 from the next period; acc is cleared, so re-enable restarts the dither pattern from acc=0.
// STRUCTURE
//  Shared package (pwm_pkg): PWM_DAT_W=14, PWM_CCW=8, PWM_FW=6, OFFSET=14'h2000.
//  Sub-module red_pitaya_pwm_sd_accu: FW-bit sigma-delta accumulator.
//    Inputs: clk, rst, ce (=boundary), clr, frac. Output: carry.
//  Top: offset/split, cnt, duty register, comparator, sync/duty outputs.
//  Two instances sit behind the DSP router, on pwm0 and pwm1.
// TESTING (CCW=8, FW=6)
//  dat_i=-8192, en_i=1 for 64 periods -> pwm_o never high; duty_o=0.
//  dat_i=0 -> duty_o=128 every period; pwm_o high in cycles 0..127; sync_o every 256 clk.
//  dat_i=1 -> exactly 1 of every 64 periods has duty 129, the rest 128; total high over 64 periods = 8193.
//  dat_i=8191 -> 63 of 64 periods at duty 256, 1 at 255; total high over 64 periods = 16383.
//  dat_i 0->4000 at cnt=100 -> current period stays 128 high.
//    The next period uses code 12192: int 190, frac 32, so duty alternates 190/191.
//  rst_i pulse at cnt=50 with pwm_o=1 -> pwm_o=0 without a clk edge.
//    After release, sync_o fires on the 2nd edge; acc restarts at 0.
//  Bonus: en_i=0 at a boundary -> duty_o=0 next period; en_i=1 -> the dither sequence repeats from acc=0.

Source files
------------

// File: rtl/red_pitaya_pwm_sd_pkg.sv
// Shared constants for the slow-analog PWM/sigma-delta output stage.
`timescale 1ns / 1ps

package pwm_pkg;

  localparam int unsigned PWM_DAT_W = 14;
  localparam int unsigned PWM_CCW   = 8;
  localparam int unsigned PWM_FW    = 6;

  localparam logic [PWM_DAT_W-1:0] OFFSET = 14'h2000;

  // Adding 8192 modulo 2^14 to a two's complement sample is just an MSB flip.
  function automatic logic [PWM_DAT_W-1:0] to_offset(input logic [PWM_DAT_W-1:0] dat);
    return dat ^ OFFSET;
  endfunction

endpackage

// File: rtl/red_pitaya_pwm_sd_accu.sv
// First-order sigma-delta accumulator: spreads the fractional duty bits over
// 2^FW PWM periods by emitting one carry each time the running sum overflows.
`timescale 1ns / 1ps

module red_pitaya_pwm_sd_accu
  import pwm_pkg::*;
#(
  parameter int unsigned FW = PWM_FW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          clr,
  input  logic [FW-1:0] frac,
  output logic          carry
);

  logic [FW-1:0] acc_q;
  logic [FW:0]   sum;

  // Carry is combinational so the top can fold it into the duty on the same edge.
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, frac};
  end

  assign carry = sum[FW];

  // Accumulator advances only at period boundaries; clr restarts the dither pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (ce) begin
      acc_q <= clr ? '0 : sum[FW-1:0];
    end
  end

endmodule

// File: rtl/red_pitaya_pwm_sd.sv
// PWM output stage with sigma-delta dithering of the fractional bits.
// The sample is latched once per period so the bitstream never glitches mid-period.
`timescale 1ns / 1ps

module red_pitaya_pwm_sd
  import pwm_pkg::*;
#(
  parameter int unsigned CCW = PWM_CCW,
  parameter int unsigned FW  = PWM_FW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PWM_DAT_W-1:0] dat_i,
  input  logic                 en_i,
  output logic                 pwm_o,
  output logic                 sync_o,
  output logic [CCW:0]         duty_o
);

  logic [PWM_DAT_W-1:0] code;
  logic [CCW-1:0]       int_part;
  logic [FW-1:0]        frac;
  logic                 carry;
  logic                 boundary;

  logic [CCW-1:0] cnt_q, cnt_d;
  logic [CCW:0]   duty_q, duty_d;
  logic           pwm_q, pwm_d;
  logic           sync_q, sync_d;

  // Offset binary split into integer duty and dither fraction.
  always_comb begin
    code     = to_offset(dat_i);
    int_part = code[PWM_DAT_W-1:FW];
    frac     = code[FW-1:0];
  end

  assign boundary = (cnt_q == {CCW{1'b1}});

  red_pitaya_pwm_sd_accu #(
    .FW (FW)
  ) u_accu (
    .clk   (clk_i),
    .rst   (rst_i),
    .ce    (boundary),
    .clr   (~en_i),
    .frac  (frac),
    .carry (carry)
  );

  // Next-state: free-running counter, duty latched at the boundary, registered compare.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    duty_d = duty_q;
    if (boundary) begin
      duty_d = en_i ? ({1'b0, int_part} + {{CCW{1'b0}}, carry}) : '0;
    end
    // Compare against the next count so pwm_o lines up with the period cycle.
    pwm_d  = ({1'b0, cnt_d} < duty_d);
    sync_d = (cnt_d == '0);
  end

  // State registers; reset parks the counter on the boundary so the first edge samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '1;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      sync_q <= sync_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign sync_o = sync_q;
  assign duty_o = duty_q;

endmodule

// File: tb/tb_red_pitaya_pwm_sd.sv
// Scoreboard bench for red_pitaya_pwm_sd (CCW=8, FW=6).
`timescale 1ns / 1ps

module tb_red_pitaya_pwm_sd;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [13:0] dat_i = '0;
  logic        en_i  = 1'b1;
  logic        pwm_o;
  logic        sync_o;
  logic [8:0]  duty_o;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pops     = 0;
  int obs_high_total = 0;
  int exp_q[$];

  red_pitaya_pwm_sd #(
    .CCW (8),
    .FW  (6)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .dat_i  (dat_i),
    .en_i   (en_i),
    .pwm_o  (pwm_o),
    .sync_o (sync_o),
    .duty_o (duty_o)
  );

  always #4 clk_i = ~clk_i;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: per-period duty from code = dat + 8192 with a running
  // fractional remainder; only the values present at each boundary edge count.
  initial begin
    int pos;
    int acc;
    int code;
    int ip;
    int fr;
    int s;
    int d;
    pos = 255;
    acc = 0;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        pos = 255;
        acc = 0;
        exp_q.delete();
      end else if (pos == 255) begin
        code = int'($signed(dat_i)) + 8192;
        ip   = code / 64;
        fr   = code % 64;
        if (en_i) begin
          s   = acc + fr;
          d   = ip + s / 64;
          acc = s % 64;
        end else begin
          d   = 0;
          acc = 0;
        end
        exp_q.push_back(d);
        pushes++;
        pos = 0;
      end else begin
        pos++;
      end
    end
  end

  // Monitor: each sync_o opens a period, which must last 256 cycles with
  // pwm_o high exactly in cycles 0..duty-1 and duty_o steady.
  initial begin
    int  k;
    int  exp_d;
    int  bad;
    bit  in_p;
    k     = 0;
    exp_d = 0;
    bad   = 0;
    in_p  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        in_p = 1'b0;
      end else begin
        if (pwm_o) obs_high_total++;
        if (sync_o) begin
          if (in_p) check(k == 256, "period_len", k, 256);
          check(exp_q.size() > 0, "expected_available", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            pops++;
            check(int'(duty_o) == exp_d, "duty_o", int'(duty_o), exp_d);
          end
          in_p = 1'b1;
          k    = 0;
          bad  = 0;
        end
        if (in_p) begin
          if (pwm_o != (k < exp_d)) bad++;
          if (int'(duty_o) != exp_d) bad++;
          k++;
          if (k == 256) check(bad == 0, "pwm_pattern_errors", bad, 0);
        end
      end
    end
  end

  // Called just after a negedge that precedes a boundary; leaves the same alignment.
  task automatic hold(input int d, input bit e, input int n, input int exp_total,
                      input string name);
    int t0;
    #1;
    dat_i = 14'(d);
    en_i  = e;
    t0    = obs_high_total;
    repeat (n * 256) @(posedge clk_i);
    @(negedge clk_i);
    if (exp_total >= 0) begin
      #1;
      check(obs_high_total - t0 == exp_total, name, obs_high_total - t0, exp_total);
    end
  endtask

  initial begin
    int d;
    int k;
    bit e;

    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check(pwm_o == 1'b0, "reset_pwm", int'(pwm_o), 0);
    check(sync_o == 1'b0, "reset_sync", int'(sync_o), 0);
    check(duty_o == 9'd0, "reset_duty", int'(duty_o), 0);
    rst_i = 1'b0;

    hold(-8192, 1'b1, 64, 0, "high_total_min");
    hold(0, 1'b1, 4, 512, "high_total_mid");
    hold(8191, 1'b1, 64, 16383, "high_total_max");

    // Mid-period sample change must not disturb the running period.
    hold(0, 1'b1, 1, -1, "pre_change");
    #1;
    dat_i = 14'd0;
    repeat (101) @(posedge clk_i);
    #1;
    dat_i = 14'(4000);
    repeat (155) @(posedge clk_i);
    @(negedge clk_i);
    hold(4000, 1'b1, 4, 4 * 190 + 2, "high_total_4000");

    // Asynchronous reset in the middle of a high phase.
    hold(0, 1'b1, 1, -1, "pre_reset");
    #1;
    repeat (51) @(posedge clk_i);
    #2;
    check(pwm_o == 1'b1, "pwm_before_reset", int'(pwm_o), 1);
    rst_i = 1'b1;
    #1;
    check(pwm_o == 1'b0, "async_reset_pwm", int'(pwm_o), 0);
    check(duty_o == 9'd0, "async_reset_duty", int'(duty_o), 0);
    check(sync_o == 1'b0, "async_reset_sync", int'(sync_o), 0);
    repeat (2) @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    hold(0, 1'b1, 2, 256, "high_total_after_reset");

    // Disable, then re-enable: dither restarts from a cleared accumulator.
    hold(1, 1'b0, 2, 0, "high_total_disabled");
    hold(1, 1'b1, 64, 8193, "high_total_plus1");

    // Random samples with junk changes inside each period.
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(0, 16383)) - 8192;
      e = ($urandom_range(0, 9) != 0);
      #1;
      dat_i = 14'(d);
      en_i  = e;
      k = int'($urandom_range(1, 254));
      repeat (k) @(posedge clk_i);
      #1;
      dat_i = 14'($urandom_range(0, 16383));
      en_i  = $urandom_range(0, 1) != 0;
      repeat (256 - k) @(posedge clk_i);
      @(negedge clk_i);
    end

    repeat (2) @(negedge clk_i);
    #1;
    check(pushes - pops <= 1, "unconsumed_expectations", pushes - pops, 1);
    check(pops >= 200, "periods_observed", pops, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
